// File: rtl/boot_rom_prefetch.sv
// boot_rom_prefetch: single-entry sequential prefetch buffer in front of the boot ROM.
// Read hits are answered from a one-word buffer one cycle after grant. Read misses go to
// the ROM and their data is passed straight through. After each read response the next
// sequential word is prefetched while the slave port is idle. Writes are rejected with an
// error response and never reach the ROM.
// Optional feature: define BOOT_ROM_PF_STATS_EN to enable saturating hit/miss counters.
// Without it, hit_cnt_o and miss_cnt_o are tied to zero.
module boot_rom_prefetch #(
    parameter logic [31:0] BASE_ADDR      = 32'h1A00_0000,
    parameter int unsigned ROM_ADDR_WIDTH = 13
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        s_req_i,
    input  logic [31:0] s_add_i,
    input  logic        s_we_i,
    output logic        s_gnt_o,
    output logic        s_r_valid_o,
    output logic [31:0] s_r_rdata_o,
    output logic        s_r_opc_o,
    output logic        m_req_o,
    output logic [31:0] m_add_o,
    input  logic        m_gnt_i,
    input  logic        m_r_valid_i,
    input  logic [31:0] m_r_rdata_i,
    output logic [31:0] hit_cnt_o,
    output logic [31:0] miss_cnt_o
);

    localparam int unsigned ROM_WORDS = 1 << (ROM_ADDR_WIDTH - 2);
    localparam logic [29:0] FIRST_TAG = BASE_ADDR[31:2];
    localparam logic [29:0] LAST_TAG  = FIRST_TAG + 30'(ROM_WORDS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DEMAND,
        ST_PF
    } state_e;

    state_e      state_q, state_d;

    logic [29:0] buf_tag_q;
    logic [31:0] buf_data_q;
    logic        buf_valid_q;
    logic        pf_pending_q;
    logic [29:0] pf_tag_q;
    logic [29:0] dem_tag_q;
    logic        flushed_q;

    logic        rsp_valid_q;
    logic        rsp_opc_q;
    logic [31:0] rsp_data_q;

    logic [29:0] s_tag;
    logic        is_idle;
    logic        hit;
    logic        read_miss;
    logic        write_req;
    logic        dem_rsp;
    logic        pf_drop;
    logic [29:0] buf_next_tag;
    logic [29:0] dem_next_tag;

    // Byte-offset bits of the slave address carry no information for word reads.
    logic        unused_addr_lsb;
    assign unused_addr_lsb = ^s_add_i[1:0];

    // True when a word address lies inside the ROM window; the last word's successor is not.
    function automatic logic in_rom(input logic [29:0] tag);
        return (tag >= FIRST_TAG) && (tag <= LAST_TAG);
    endfunction

    assign s_tag        = s_add_i[31:2];
    assign is_idle      = (state_q == ST_IDLE);
    // A flush in the same cycle wins over a hit, so the request falls through to the ROM.
    assign hit          = is_idle & s_req_i & ~s_we_i & buf_valid_q & (s_tag == buf_tag_q) & ~flush_i;
    assign read_miss    = is_idle & s_req_i & ~s_we_i & ~hit;
    assign write_req    = is_idle & s_req_i & s_we_i;
    assign dem_rsp      = (state_q == ST_DEMAND) & m_r_valid_i;
    assign pf_drop      = flushed_q | flush_i;
    assign buf_next_tag = buf_tag_q + 30'd1;
    assign dem_next_tag = dem_tag_q + 30'd1;

    // State register.
    // NOTE: sequential state is updated with non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and bus handshakes; the slave request always outranks the prefetch.
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        s_gnt_o = 1'b0;
        m_req_o = 1'b0;
        m_add_o = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (s_req_i) begin
                    if (s_we_i || hit) begin
                        s_gnt_o = 1'b1;
                    end else begin
                        m_req_o = 1'b1;
                        m_add_o = {s_tag, 2'b00};
                        s_gnt_o = m_gnt_i;
                        if (m_gnt_i) state_d = ST_DEMAND;
                    end
                end else if (pf_pending_q && !flush_i) begin
                    m_req_o = 1'b1;
                    m_add_o = {pf_tag_q, 2'b00};
                    if (m_gnt_i) state_d = ST_PF;
                end
            end
            ST_DEMAND: if (m_r_valid_i) state_d = ST_IDLE;
            ST_PF:     if (m_r_valid_i) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Buffer contents, prefetch bookkeeping and flush tracking for the outstanding ROM access.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            buf_tag_q    <= '0;
            buf_data_q   <= '0;
            buf_valid_q  <= 1'b0;
            pf_pending_q <= 1'b0;
            pf_tag_q     <= '0;
            dem_tag_q    <= '0;
            flushed_q    <= 1'b0;
        end else begin
            if (flush_i) begin
                buf_valid_q  <= 1'b0;
                pf_pending_q <= 1'b0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    flushed_q <= 1'b0;
                    if (hit) begin
                        pf_tag_q     <= buf_next_tag;
                        pf_pending_q <= in_rom(buf_next_tag);
                    end else if (read_miss && m_gnt_i) begin
                        buf_valid_q  <= 1'b0;
                        pf_pending_q <= 1'b0;
                        dem_tag_q    <= s_tag;
                    end
                end
                ST_DEMAND: begin
                    flushed_q <= pf_drop;
                    if (m_r_valid_i) begin
                        pf_tag_q     <= dem_next_tag;
                        pf_pending_q <= ~pf_drop & in_rom(dem_next_tag);
                    end
                end
                ST_PF: begin
                    flushed_q <= pf_drop;
                    if (m_r_valid_i) begin
                        pf_pending_q <= 1'b0;
                        if (!pf_drop) begin
                            buf_data_q  <= m_r_rdata_i;
                            buf_tag_q   <= pf_tag_q;
                            buf_valid_q <= 1'b1;
                        end
                    end
                end
                default: flushed_q <= 1'b0;
            endcase
        end
    end

    // Registered responses for hits and rejected writes, delivered one cycle after grant.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rsp_valid_q <= 1'b0;
            rsp_opc_q   <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= hit | write_req;
            rsp_opc_q   <= write_req;
            rsp_data_q  <= hit ? buf_data_q : 32'h0;
        end
    end

    // Demand data is forwarded in the same cycle it returns from the ROM.
    assign s_r_valid_o = rsp_valid_q | dem_rsp;
    assign s_r_opc_o   = rsp_opc_q;
    assign s_r_rdata_o = dem_rsp ? m_r_rdata_i : rsp_data_q;

`ifdef BOOT_ROM_PF_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating counters of granted hits and granted read misses; flush does not clear them.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (read_miss && m_gnt_i && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'h0;
    assign miss_cnt_o = 32'h0;
`endif

endmodule

// File: tb/tb_boot_rom_prefetch.sv
// Directed self-checking bench for boot_rom_prefetch. A small ROM responder grants every
// request (unless stalled) and returns data one cycle later; word n of the ROM holds
// 32'hAAAA_0000 + n. Inputs change on the falling edge, outputs are checked 1 ns later.
module tb_boot_rom_prefetch;

    localparam logic [31:0] BASE = 32'h1A00_0000;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        s_req;
    logic [31:0] s_add;
    logic        s_we;
    logic        s_gnt;
    logic        s_r_valid;
    logic [31:0] s_r_rdata;
    logic        s_r_opc;
    logic        m_req;
    logic [31:0] m_add;
    logic        m_gnt;
    logic        rom_rv = 1'b0;
    logic [31:0] rom_rd = 32'h0;
    logic        rom_stall;
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;

    int errors = 0;
    int checks = 0;

    boot_rom_prefetch #(
        .BASE_ADDR      (BASE),
        .ROM_ADDR_WIDTH (13)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .s_req_i     (s_req),
        .s_add_i     (s_add),
        .s_we_i      (s_we),
        .s_gnt_o     (s_gnt),
        .s_r_valid_o (s_r_valid),
        .s_r_rdata_o (s_r_rdata),
        .s_r_opc_o   (s_r_opc),
        .m_req_o     (m_req),
        .m_add_o     (m_add),
        .m_gnt_i     (m_gnt),
        .m_r_valid_i (rom_rv),
        .m_r_rdata_i (rom_rd),
        .hit_cnt_o   (hit_cnt),
        .miss_cnt_o  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'hAAAA_0000 + ((a - BASE) >> 2);
    endfunction

    // ROM responder: independent of the DUT reset so in-flight data really is in flight.
    assign m_gnt = m_req & ~rom_stall;
    always @(posedge clk) begin
        rom_rv <= m_req & m_gnt;
        rom_rd <= (m_req & m_gnt) ? rom_word(m_add) : 32'h0;
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_req = 1'b0; s_we = 1'b0; flush = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; s_req = 1'b0; s_add = 32'h0; s_we = 1'b0; rom_stall = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %h want 0", s_gnt); end
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %h want 0", s_r_valid); end
        checks++; if (s_r_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", s_r_rdata); end
        checks++; if (s_r_opc !== 1'b0) begin errors++; $display("FAIL reset_opc: got %h want 0", s_r_opc); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_mreq: got %h want 0", m_req); end
        checks++; if (m_add !== 32'h0) begin errors++; $display("FAIL reset_madd: got %h want 0", m_add); end
        checks++; if (hit_cnt !== 32'h0) begin errors++; $display("FAIL reset_hitcnt: got %h want 0", hit_cnt); end
        checks++; if (miss_cnt !== 32'h0) begin errors++; $display("FAIL reset_misscnt: got %h want 0", miss_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Cold read of word 0, then the automatic prefetch of word 1.
    task automatic test_demand();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0000; s_we = 1'b0; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL dem_mreq: got %h want 1", m_req); end
        checks++; if (m_add !== 32'h1A00_0000) begin errors++; $display("FAIL dem_madd: got %h want 1a000000", m_add); end
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL dem_gnt: got %h want 1", s_gnt); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_valid !== 1'b1) begin errors++; $display("FAIL dem_rvalid: got %h want 1", s_r_valid); end
        checks++; if (s_r_rdata !== 32'hAAAA_0000) begin errors++; $display("FAIL dem_rdata: got %h want aaaa0000", s_r_rdata); end
        checks++; if (s_r_opc !== 1'b0) begin errors++; $display("FAIL dem_opc: got %h want 0", s_r_opc); end
        @(negedge clk); #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL dem_pf_req: got %h want 1", m_req); end
        checks++; if (m_add !== 32'h1A00_0004) begin errors++; $display("FAIL dem_pf_add: got %h want 1a000004", m_add); end
        @(negedge clk); #1;
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL pf_not_forwarded: got %h want 0", s_r_valid); end
        @(negedge clk); #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL dem_quiet: got %h want 0", m_req); end
    endtask

    // Word 1 sits in the buffer: granted at once, answered one cycle later, word 2 prefetched.
    task automatic test_hit();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0004; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL hit_gnt: got %h want 1", s_gnt); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL hit_no_mreq: got %h want 0", m_req); end
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL hit_not_early: got %h want 0", s_r_valid); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_valid !== 1'b1) begin errors++; $display("FAIL hit_rvalid: got %h want 1", s_r_valid); end
        checks++; if (s_r_rdata !== 32'hAAAA_0001) begin errors++; $display("FAIL hit_rdata: got %h want aaaa0001", s_r_rdata); end
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL hit_pf_req: got %h want 1", m_req); end
        checks++; if (m_add !== 32'h1A00_0008) begin errors++; $display("FAIL hit_pf_add: got %h want 1a000008", m_add); end
        idle(2);
    endtask

    // Hit on word 2 followed directly by a write; the write outranks the pending prefetch.
    task automatic test_back_to_back();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0008; s_we = 1'b0; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL b2b_hit_gnt: got %h want 1", s_gnt); end
        @(negedge clk); s_we = 1'b1; s_add = 32'h1A00_0010; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL b2b_wr_gnt: got %h want 1", s_gnt); end
        checks++; if (s_r_rdata !== 32'hAAAA_0002) begin errors++; $display("FAIL b2b_hit_rdata: got %h want aaaa0002", s_r_rdata); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL b2b_slave_prio: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b0; s_we = 1'b0; #1;
        checks++; if (s_r_opc !== 1'b1) begin errors++; $display("FAIL b2b_wr_opc: got %h want 1", s_r_opc); end
        checks++; if (s_r_rdata !== 32'h0) begin errors++; $display("FAIL b2b_wr_rdata: got %h want 0", s_r_rdata); end
        checks++; if (m_add !== 32'h1A00_000C) begin errors++; $display("FAIL b2b_pf_add: got %h want 1a00000c", m_add); end
        idle(2);
    endtask

    // Write on an idle port: error response, ROM untouched, buffer (word 3) still hits afterwards.
    task automatic test_write();
        @(negedge clk); s_req = 1'b1; s_we = 1'b1; s_add = 32'h1A00_0010; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt: got %h want 1", s_gnt); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL wr_mreq: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b0; s_we = 1'b0; #1;
        checks++; if (s_r_valid !== 1'b1) begin errors++; $display("FAIL wr_rvalid: got %h want 1", s_r_valid); end
        checks++; if (s_r_opc !== 1'b1) begin errors++; $display("FAIL wr_opc: got %h want 1", s_r_opc); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL wr_mreq_after: got %h want 0", m_req); end
        @(negedge clk); #1;
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL wr_single_rsp: got %h want 0", s_r_valid); end
        checks++; if (s_r_opc !== 1'b0) begin errors++; $display("FAIL wr_opc_clear: got %h want 0", s_r_opc); end
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_000C; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL wr_buf_kept: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_0003) begin errors++; $display("FAIL wr_hit_rdata: got %h want aaaa0003", s_r_rdata); end
        idle(2);
    endtask

    // Last ROM word: served, but its successor is outside the ROM so nothing is prefetched.
    task automatic test_last_word();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_1FFC; #1;
        checks++; if (m_add !== 32'h1A00_1FFC) begin errors++; $display("FAIL last_madd: got %h want 1a001ffc", m_add); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_07FF) begin errors++; $display("FAIL last_rdata: got %h want aaaa07ff", s_r_rdata); end
        @(negedge clk); #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL last_no_pf: got %h want 0", m_req); end
        @(negedge clk); #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL last_no_pf2: got %h want 0", m_req); end
        // Word 4 was buffered before the demand; the demand invalidated it.
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0010; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL last_buf_inval: got %h want 1", m_req); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_0004) begin errors++; $display("FAIL last_w4_rdata: got %h want aaaa0004", s_r_rdata); end
        idle(3);
    endtask

    // ROM withholds grant for a cycle: slave grant must follow it.
    task automatic test_rom_stall();
        @(negedge clk); rom_stall = 1'b1; s_req = 1'b1; s_add = 32'h1A00_0080; #1;
        checks++; if (s_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt: got %h want 0", s_gnt); end
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL stall_mreq: got %h want 1", m_req); end
        @(negedge clk); rom_stall = 1'b0; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL stall_gnt_late: got %h want 1", s_gnt); end
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL stall_no_rsp: got %h want 0", s_r_valid); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_0020) begin errors++; $display("FAIL stall_rdata: got %h want aaaa0020", s_r_rdata); end
        idle(3);
    endtask

    // Flush while a prefetch is in PF: the prefetched word is dropped and must be re-fetched.
    task automatic test_flush();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0020; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fl_dem_mreq: got %h want 1", m_req); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_0008) begin errors++; $display("FAIL fl_dem_rdata: got %h want aaaa0008", s_r_rdata); end
        @(negedge clk); #1;
        checks++; if (m_add !== 32'h1A00_0024) begin errors++; $display("FAIL fl_pf_add: got %h want 1a000024", m_add); end
        @(negedge clk); flush = 1'b1; #1;
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL fl_pf_rvalid: got %h want 0", s_r_valid); end
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fl_quiet: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0024; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL fl_reread_miss: got %h want 1", m_req); end
        checks++; if (m_add !== 32'h1A00_0024) begin errors++; $display("FAIL fl_reread_add: got %h want 1a000024", m_add); end
        @(negedge clk); s_req = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_0009) begin errors++; $display("FAIL fl_reread_rdata: got %h want aaaa0009", s_r_rdata); end
        idle(3);
    endtask

    // Flush coinciding with a would-be hit on word 10 turns it into a ROM access.
    task automatic test_flush_hit();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0028; flush = 1'b1; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL flhit_mreq: got %h want 1", m_req); end
        checks++; if (m_add !== 32'h1A00_0028) begin errors++; $display("FAIL flhit_madd: got %h want 1a000028", m_add); end
        @(negedge clk); s_req = 1'b0; flush = 1'b0; #1;
        checks++; if (s_r_rdata !== 32'hAAAA_000A) begin errors++; $display("FAIL flhit_rdata: got %h want aaaa000a", s_r_rdata); end
        idle(3);
    endtask

    // Flush during DEMAND: data still delivered, no prefetch armed.
    task automatic test_flush_demand();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0040; #1;
        checks++; if (s_gnt !== 1'b1) begin errors++; $display("FAIL fldem_gnt: got %h want 1", s_gnt); end
        @(negedge clk); s_req = 1'b0; flush = 1'b1; #1;
        checks++; if (s_r_valid !== 1'b1) begin errors++; $display("FAIL fldem_rvalid: got %h want 1", s_r_valid); end
        checks++; if (s_r_rdata !== 32'hAAAA_0010) begin errors++; $display("FAIL fldem_rdata: got %h want aaaa0010", s_r_rdata); end
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL fldem_no_pf: got %h want 0", m_req); end
    endtask

    // Reset while a demand response is in flight; afterwards nothing is pending.
    task automatic test_reset_mid();
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0100; #1;
        @(negedge clk); s_req = 1'b0; rst_n = 1'b0; #1;
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL rstmid_rvalid: got %h want 0", s_r_valid); end
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_mreq: got %h want 0", m_req); end
        @(negedge clk); rst_n = 1'b1; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL rstmid_no_pf: got %h want 0", m_req); end
        checks++; if (s_r_valid !== 1'b0) begin errors++; $display("FAIL rstmid_dropped: got %h want 0", s_r_valid); end
    endtask

    // miss, hit, hit, miss from a fresh reset.
    task automatic test_stats();
        logic [31:0] exp_hit;
        logic [31:0] exp_miss;
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0000; #1;
        @(negedge clk); s_req = 1'b0; idle(3);
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0004; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL st_hit1: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b0; idle(2);
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0008; #1;
        checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL st_hit2: got %h want 0", m_req); end
        @(negedge clk); s_req = 1'b1; s_add = 32'h1A00_0200; #1;
        checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL st_miss2: got %h want 1", m_req); end
        @(negedge clk); s_req = 1'b0; #1;
`ifdef BOOT_ROM_PF_STATS_EN
        exp_hit = 32'd2; exp_miss = 32'd2;
`else
        exp_hit = 32'd0; exp_miss = 32'd0;
`endif
        checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL st_hitcnt: got %0d want %0d", hit_cnt, exp_hit); end
        checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL st_misscnt: got %0d want %0d", miss_cnt, exp_miss); end
        // Flush must leave the counters alone.
        @(negedge clk); flush = 1'b1;
        @(negedge clk); flush = 1'b0; #1;
        checks++; if (hit_cnt !== exp_hit) begin errors++; $display("FAIL st_hitcnt_flush: got %0d want %0d", hit_cnt, exp_hit); end
        checks++; if (miss_cnt !== exp_miss) begin errors++; $display("FAIL st_misscnt_flush: got %0d want %0d", miss_cnt, exp_miss); end
    endtask

    initial begin
        test_reset();
        test_demand();
        test_hit();
        test_back_to_back();
        test_write();
        test_last_word();
        test_rom_stall();
        test_flush();
        test_flush_hit();
        test_flush_demand();
        test_reset_mid();
        test_stats();
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
